// File: rtl/reg_file_param.sv
// reg_file_param: DEPTH x WIDTH register file, one write port, two combinational
// read ports, optional hard-wired zero entry. Reset runs a one-entry-per-cycle
// clear engine so the array needs no per-bit reset.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_param #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned ADDR_W   = 3,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  din,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  dout_a,
   output logic [WIDTH-1:0]  dout_b,
   output logic              ready
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [WIDTH-1:0]  mem_wdata;

   // State and clear counter; reset restarts the clear from entry 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StInit;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and write-port steering: the clear engine owns the port during INIT.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_waddr = waddr;
      mem_wdata = din;
      unique case (state_q)
         StInit: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[ADDR_W-1:0];
            mem_wdata = '0;
            cnt_d     = cnt_q + 1'b1;
            // The edge that clears entry DEPTH-1 is the one that reaches DEPTH.
            if (cnt_d == (ADDR_W + 1)'(DEPTH)) begin
               state_d = StRun;
            end
         end
         StRun: begin
            mem_we = we && !(ZERO_REG && (waddr == '0));
         end
         default: begin
            state_d = StInit;
         end
      endcase
   end

   // Storage array, deliberately without reset so it maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Read port A: array value, optional forwarding, then zero-register and INIT masks.
   always_comb begin
      dout_a = mem_q[raddr_a];
`ifdef REGFILE_BYPASS_EN
      if ((state_q == StRun) && we && (raddr_a == waddr)) begin
         dout_a = din;
      end
`endif
      if (ZERO_REG && (raddr_a == '0)) begin
         dout_a = '0;
      end
      if (state_q != StRun) begin
         dout_a = '0;
      end
   end

   // Read port B: identical to port A, fully independent.
   always_comb begin
      dout_b = mem_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
      if ((state_q == StRun) && we && (raddr_b == waddr)) begin
         dout_b = din;
      end
`endif
      if (ZERO_REG && (raddr_b == '0)) begin
         dout_b = '0;
      end
      if (state_q != StRun) begin
         dout_b = '0;
      end
   end

   assign ready = (state_q == StRun);

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param (default parameters).
module tb_reg_file_param;

   logic        clk;
   logic        rst;
   logic        we;
   logic [2:0]  waddr;
   logic [15:0] din;
   logic [2:0]  raddr_a;
   logic [2:0]  raddr_b;
   logic [15:0] dout_a;
   logic [15:0] dout_b;
   logic        ready;

   int n_checks = 0;
   int n_errors = 0;

   reg_file_param #(
      .WIDTH    (16),
      .ADDR_W   (3),
      .ZERO_REG (1'b1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .waddr   (waddr),
      .din     (din),
      .raddr_a (raddr_a),
      .raddr_b (raddr_b),
      .dout_a  (dout_a),
      .dout_b  (dout_b),
      .ready   (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      we    = 1'b1;
      waddr = a;
      din   = d;
      step();
      we    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; waddr = '0; din = '0; raddr_a = 3'd3; raddr_b = 3'd7;

      // Reset held for three cycles.
      repeat (3) step();
      check_eq("rst_ready", 16'(ready), 16'h0);
      check_eq("rst_dout_a", dout_a, 16'h0);
      check_eq("rst_dout_b", dout_b, 16'h0);

      // Clear sequence: ready rises on the 8th edge after release.
      rst = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         check_eq("clr_ready", 16'(ready), 16'(i == 8));
      end
      for (int a = 0; a < 8; a++) begin
         raddr_a = 3'(a);
         raddr_b = 3'(7 - a);
         #1;
         check_eq("clr_read_a", dout_a, 16'h0);
         check_eq("clr_read_b", dout_b, 16'h0);
      end

      // Write then read on both ports.
      wr(3'd5, 16'hBEEF);
      raddr_a = 3'd5; raddr_b = 3'd5;
      #1;
      check_eq("wr_a5", dout_a, 16'hBEEF);
      check_eq("wr_b5", dout_b, 16'hBEEF);

      // Zero register discards writes.
      wr(3'd0, 16'h1234);
      raddr_a = 3'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("zero_reg", dout_a, 16'h0);
         step();
      end

      // Last write wins on consecutive writes.
      wr(3'd6, 16'h1111);
      wr(3'd6, 16'h2222);
      raddr_b = 3'd6;
      #1;
      check_eq("last_wins", dout_b, 16'h2222);

      // Same-cycle read/write on address 2.
      wr(3'd2, 16'h0011);
      we = 1'b1; waddr = 3'd2; din = 16'h5A5A; raddr_a = 3'd2;
      #1;
`ifdef REGFILE_BYPASS_EN
      check_eq("same_cycle", dout_a, 16'h5A5A);
`else
      check_eq("same_cycle", dout_a, 16'h0011);
`endif
      step();
      we = 1'b0;
      #1;
      check_eq("after_edge", dout_a, 16'h5A5A);

      // Reset from RUN after filling every nonzero entry with 0xFFFF.
      for (int a = 1; a < 8; a++) wr(3'(a), 16'hFFFF);
      raddr_a = 3'd3; raddr_b = 3'd7;
      #1;
      check_eq("fill_a3", dout_a, 16'hFFFF);
      check_eq("fill_b7", dout_b, 16'hFFFF);
      rst = 1'b1;
      step();
      check_eq("run_rst_ready", 16'(ready), 16'h0);
      check_eq("run_rst_a", dout_a, 16'h0);
      check_eq("run_rst_b", dout_b, 16'h0);
      rst = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         check_eq("run_rst_clr", 16'(ready), 16'(i == 8));
      end
      for (int a = 0; a < 8; a++) begin
         raddr_a = 3'(a);
         raddr_b = 3'(a);
         #1;
         check_eq("run_rst_read_a", dout_a, 16'h0);
         check_eq("run_rst_read_b", dout_b, 16'h0);
      end

      // Reset mid-INIT at cnt=4; writes during INIT are ignored and reads are masked.
      wr(3'd3, 16'h7777);
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (4) step();
      check_eq("mid_init_ready", 16'(ready), 16'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      we = 1'b1; waddr = 3'd3; din = 16'hAAAA; raddr_a = 3'd3;
      for (int i = 1; i <= 8; i++) begin
         #1;
         check_eq("init_masked", dout_a, 16'h0);
         step();
         check_eq("mid_init_clr", 16'(ready), 16'(i == 8));
      end
      we = 1'b0;
      #1;
      check_eq("init_we_ignored", dout_a, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised multi-entry register file that generalises the single 16-bit write-enabled register into DEPTH entries of WIDTH bits, with one write port, two combinational read ports and an optional hard-wired zero register. It sits between instruction decode and the ALU in the single-cycle core and supplies both source operands each cycle. Reset runs a sequential clear engine that zeroes one entry per cycle, so the array maps onto distributed RAM without a per-bit reset net. A `ready` flag tells the core when the array is usable.

## Interface
- `WIDTH`, 16, data width of each entry
- `ADDR_W`, 3, address width; DEPTH = 2**ADDR_W entries
- `ZERO_REG`, 1, when 1 entry 0 always reads 0 and writes to it are discarded
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `we`  in  1  write enable
- `waddr`  in  ADDR_W  write address
- `din`  in  WIDTH  write data
- `raddr_a`  in  ADDR_W  read address, port A
- `raddr_b`  in  ADDR_W  read address, port B
- `dout_a`  out  WIDTH  read data, port A (combinational)
- `dout_b`  out  WIDTH  read data, port B (combinational)
- `ready`  out  1  1 when the clear sequence has finished and the array accepts writes

## Operation
- State machine with two states: INIT and RUN. Clear counter `cnt` is ADDR_W+1 bits wide.
- `rst`=1 at an edge forces state to INIT and `cnt` to 0, regardless of the current state. A reset in RUN or partway through INIT restarts the clear at entry 0.
- INIT with `rst`=0: each edge writes 0 to entry `cnt[ADDR_W-1:0]` and increments `cnt`.
  - The edge that clears entry DEPTH-1 moves the state to RUN.
  - `we` is ignored for the whole of INIT.
- RUN:
  - `we`=1 at an edge writes `din` to `waddr`.
  - If ZERO_REG=1 and `waddr`=0, the write is discarded.
  - `we`=0 leaves the array unchanged.
- Reads:
  - `dout_x` = array[`raddr_x`].
  - `dout_x` is forced to 0 when `raddr_x`=0 and ZERO_REG=1.
  - `dout_x` is forced to 0 whenever the state is INIT, so stale contents never reach the datapath.
- Both read ports are fully independent. They may use the same address, and either may match `waddr`.
- `ready` = (state == RUN). It is a registered-state decode with no combinational path from inputs.

## Timing
- Reset values: `ready`=0, `dout_a`=`dout_b`=0, state INIT, `cnt`=0. Array contents are undefined until cleared.
- Clear latency: `ready` rises exactly DEPTH rising edges after the first edge that samples `rst`=0. With the default parameters this is 8 cycles.
- Holding `rst` high for multiple cycles keeps `cnt` at 0. The clear sequence does not advance while `rst` is high.
- Write latency: data written at edge k is visible on a read port from edge k onward.
- Same address written and read in the same cycle: the read returns the old value until the edge, unless bypass is enabled (see Configuration).
- Two writes to the same address on consecutive edges: the last write wins.
- `waddr`/`raddr` at DEPTH-1: no wrap-around behaviour is needed because the address width exactly spans DEPTH.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: write-to-read forwarding is enabled.
  - In RUN, when `we`=1 and `raddr_x`==`waddr`, `dout_x`=`din` combinationally in the same cycle.
  - Forwarding is suppressed for address 0 when ZERO_REG=1.
  - Forwarding is suppressed in INIT.
- Undefined: there is no forwarding path; reads always return the array contents.
- The macro must not change `ready` timing or clear behaviour.

## Test plan
- Reset and clear: assert `rst` for 3 cycles, then release. Required: `ready`=0 for the next 7 edges and `ready`=1 after the 8th. Reading all 8 addresses then returns 0x0000.
- Write and read: in RUN, write 0xBEEF to address 5. Required: on the next cycle `dout_a`=0xBEEF with `raddr_a`=5, and `dout_b`=0xBEEF with `raddr_b`=5 at the same time.
- Zero register: write 0x1234 to address 0. Required: `dout_a`=0x0000 with `raddr_a`=0 on every following cycle.
- Reset mid-INIT: pulse `rst` high while `cnt`=4. Required: `ready` rises exactly 8 edges after `rst` falls, and `we`=1 with `waddr`=3, `din`=0xAAAA during INIT leaves address 3 reading 0x0000 afterwards.
- Same-cycle read/write on address 2 (old value 0x0011, new value 0x5A5A):
  - With `REGFILE_BYPASS_EN`: `dout_a`=0x5A5A in the write cycle.
  - Without it: `dout_a`=0x0011 in the write cycle and 0x5A5A after the edge.
- Reset from RUN: load 0xFFFF into every nonzero address, then assert `rst`. Required: `ready`=0 and both outputs read 0 immediately after the reset edge, and all entries read 0x0000 once `ready` returns.
